// File: rtl/alt_vipitc120_mode_pkg.sv
// Shared definitions for the clocked-video-output mode-switch controller.
// Provides the controller state encoding, a one-hot test helper and the
// default number of video modes used by the controller and its checker.
package alt_vipitc120_mode_pkg;

    localparam int DEFAULT_NO_OF_MODES = 3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_EOF = 2'd1,
        SETTLE   = 2'd2
    } state_t;

    // Callers zero-extend narrower vectors; extra zero bits do not change the result.
    function automatic logic is_one_hot(input logic [31:0] vec);
        return $countones(vec) == 1;
    endfunction

endpackage

// File: rtl/alt_vipitc120_onehot_check.sv
// Combinational request/mode qualifier for the mode-switch controller.
// Ports:
//   req_mode    in   requested mode (one-hot expected)
//   mode_valid  in   per-mode valid bits
//   one_hot     in   currently active mode (registered in the controller)
//   legal       out  request is one-hot and its mode is valid
//   active_lost out  an active mode exists and its valid bit has dropped
module alt_vipitc120_onehot_check
    import alt_vipitc120_mode_pkg::*;
#(
    parameter int NO_OF_MODES = DEFAULT_NO_OF_MODES
) (
    input  logic [NO_OF_MODES-1:0] req_mode,
    input  logic [NO_OF_MODES-1:0] mode_valid,
    input  logic [NO_OF_MODES-1:0] one_hot,
    output logic                   legal,
    output logic                   active_lost
);

    assign legal       = is_one_hot(32'(req_mode)) && (|(req_mode & mode_valid));
    // All-zero ("no mode") can never be lost.
    assign active_lost = (|one_hot) && !(|(one_hot & mode_valid));

endmodule

// File: rtl/alt_vipitc120_mode_switch_ctrl.sv
// Mode-select controller for the clocked-video-output timing path.
// Validates one-hot mode requests, commits them only on end-of-frame, then
// holds a settle window during which the timing generator keeps blanking.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   mode_valid      per-mode valid bits (level)
//   req_mode        requested one-hot mode, sampled with req_strobe
//   req_strobe      1-cycle request pulse
//   eof             end-of-frame pulse
//   one_hot         active mode, registered; all-zero means "no mode"
//   mode_change     1-cycle pulse on each commit
//   mode_switching  high during the settle window
//   req_error       1-cycle pulse for a rejected or cancelled request
//   busy            high whenever the controller is not IDLE
module alt_vipitc120_mode_switch_ctrl
    import alt_vipitc120_mode_pkg::*;
#(
    parameter int NO_OF_MODES   = DEFAULT_NO_OF_MODES,
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_WIDTH     = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NO_OF_MODES-1:0] mode_valid,
    input  logic [NO_OF_MODES-1:0] req_mode,
    input  logic                   req_strobe,
    input  logic                   eof,
    output logic [NO_OF_MODES-1:0] one_hot,
    output logic                   mode_change,
    output logic                   mode_switching,
    output logic                   req_error,
    output logic                   busy
);

    state_t                 state, state_next;
    logic [NO_OF_MODES-1:0] pend, pend_next;
    logic                   pend_flag, pend_flag_next;
    logic [CNT_WIDTH-1:0]   cnt, cnt_next;
    logic [NO_OF_MODES-1:0] one_hot_next;
    logic                   mode_change_next;
    logic                   req_error_next;
    logic                   legal;
    logic                   active_lost;
    logic                   pend_lost;
    logic                   req_ok;
    logic                   req_bad;

    alt_vipitc120_onehot_check #(
        .NO_OF_MODES(NO_OF_MODES)
    ) u_check (
        .req_mode   (req_mode),
        .mode_valid (mode_valid),
        .one_hot    (one_hot),
        .legal      (legal),
        .active_lost(active_lost)
    );

    // A zero pend is the deliberate "no mode" commit and is never cancelled.
    assign pend_lost = (|pend) && !(|(pend & mode_valid));
    assign req_ok    = req_strobe && legal;
    assign req_bad   = req_strobe && !legal;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_next       = state;
        pend_next        = pend;
        pend_flag_next   = pend_flag;
        cnt_next         = cnt;
        one_hot_next     = one_hot;
        mode_change_next = 1'b0;
        req_error_next   = req_bad;

        case (state)
            IDLE: begin
                if (req_ok) begin
                    if (req_mode != one_hot) begin
                        pend_next  = req_mode;
                        state_next = WAIT_EOF;
                    end
                end else if (active_lost) begin
                    pend_next  = '0;
                    state_next = WAIT_EOF;
                end
            end

            WAIT_EOF: begin
                if (pend_lost) begin
                    req_error_next = 1'b1;
                    pend_next      = '0;
                    state_next     = IDLE;
                end else if (eof) begin
                    // The old pend commits; a same-cycle request waits for the next frame.
                    one_hot_next     = pend;
                    mode_change_next = 1'b1;
                    cnt_next         = CNT_WIDTH'(SETTLE_CYCLES - 1);
                    state_next       = SETTLE;
                    pend_flag_next   = req_ok;
                    if (req_ok) begin
                        pend_next = req_mode;
                    end
                end else if (req_ok) begin
                    pend_next = req_mode;
                end
            end

            SETTLE: begin
                if (req_ok) begin
                    pend_next      = req_mode;
                    pend_flag_next = 1'b1;
                end
                if (cnt == '0) begin
                    state_next     = pend_flag_next ? WAIT_EOF : IDLE;
                    pend_flag_next = 1'b0;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            pend           <= '0;
            pend_flag      <= 1'b0;
            cnt            <= '0;
            one_hot        <= '0;
            mode_change    <= 1'b0;
            mode_switching <= 1'b0;
            req_error      <= 1'b0;
            busy           <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state          <= state_next;
            pend           <= pend_next;
            pend_flag      <= pend_flag_next;
            cnt            <= cnt_next;
            one_hot        <= one_hot_next;
            mode_change    <= mode_change_next;
            mode_switching <= (state_next == SETTLE);
            req_error      <= req_error_next;
            busy           <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_alt_vipitc120_mode_switch_ctrl.sv
// Self-checking bench for alt_vipitc120_mode_switch_ctrl.
// Stimulus pushes expected commits/errors into queues; a negedge monitor pops
// and compares whenever mode_change or req_error is presented.
module tb_alt_vipitc120_mode_switch_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] mode_valid;
    logic [2:0] req_mode;
    logic       req_strobe;
    logic       eof;
    logic [2:0] one_hot;
    logic       mode_change;
    logic       mode_switching;
    logic       req_error;
    logic       busy;

    int total = 0;
    int bad   = 0;

    logic [2:0] exp_commit[$];
    int         exp_error = 0;

    alt_vipitc120_mode_switch_ctrl #(
        .NO_OF_MODES  (3),
        .SETTLE_CYCLES(4),
        .CNT_WIDTH    (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mode_valid    (mode_valid),
        .req_mode      (req_mode),
        .req_strobe    (req_strobe),
        .eof           (eof),
        .one_hot       (one_hot),
        .mode_change   (mode_change),
        .mode_switching(mode_switching),
        .req_error     (req_error),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: consume expected events as the DUT presents them.
    always @(negedge clk) begin
        if (!rst) begin
            if (mode_change) begin
                if (exp_commit.size() == 0) begin
                    check("unexpected_commit", {29'd0, one_hot}, 32'hFFFF_FFFF);
                end else begin
                    check("commit_value", {29'd0, one_hot}, {29'd0, exp_commit.pop_front()});
                end
            end
            if (req_error) begin
                check("error_expected", (exp_error > 0) ? 1 : 0, 1);
                if (exp_error > 0) exp_error--;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [2:0] m);
        req_mode   = m;
        req_strobe = 1'b1;
        tick();
        req_strobe = 1'b0;
    endtask

    task automatic pulse_eof();
        eof = 1'b1;
        tick();
        eof = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        check("idle_timeout", {31'd0, busy}, 0);
    endtask

    initial begin
        int n;
        rst        = 1'b1;
        mode_valid = 3'b111;
        req_mode   = 3'b000;
        req_strobe = 1'b0;
        eof        = 1'b0;
        #12;
        check("rst_one_hot", {29'd0, one_hot}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_switching", {31'd0, mode_switching}, 0);
        tick();
        rst = 1'b0;
        tick();

        // Basic commit with settle window length.
        strobe(3'b010);
        exp_commit.push_back(3'b010);
        check("busy_after_req", {31'd0, busy}, 1);
        repeat (4) tick();
        check("no_early_commit", {29'd0, one_hot}, 0);
        pulse_eof();
        check("one_hot_after_eof", {29'd0, one_hot}, 3'b010);
        check("mode_change_after_eof", {31'd0, mode_change}, 1);
        n = 0;
        while (mode_switching && n < 20) begin
            n++;
            tick();
        end
        check("settle_len", n, 4);
        check("busy_after_settle", {31'd0, busy}, 0);

        // Illegal requests.
        mode_valid = 3'b011;
        tick();
        strobe(3'b110);
        exp_error++;
        check("err_two_hot_pulse", {31'd0, req_error}, 1);
        check("err_two_hot_busy", {31'd0, busy}, 0);
        strobe(3'b100);
        exp_error++;
        check("err_invalid_pulse", {31'd0, req_error}, 1);
        check("err_invalid_one_hot", {29'd0, one_hot}, 3'b010);
        check("err_invalid_busy", {31'd0, busy}, 0);
        // Request equal to active mode is ignored.
        strobe(3'b010);
        check("same_mode_busy", {31'd0, busy}, 0);
        check("same_mode_no_err", {31'd0, req_error}, 0);
        mode_valid = 3'b111;
        tick();

        // Last request before eof wins.
        strobe(3'b001);
        tick();
        strobe(3'b100);
        exp_commit.push_back(3'b100);
        pulse_eof();
        wait_idle();
        check("last_wins", {29'd0, one_hot}, 3'b100);

        // Back to 010, then simultaneous eof and new request.
        strobe(3'b010);
        exp_commit.push_back(3'b010);
        pulse_eof();
        wait_idle();
        strobe(3'b100);
        exp_commit.push_back(3'b100);
        exp_commit.push_back(3'b001);
        req_mode   = 3'b001;
        req_strobe = 1'b1;
        eof        = 1'b1;
        tick();
        req_strobe = 1'b0;
        eof        = 1'b0;
        check("simul_commit_old", {29'd0, one_hot}, 3'b100);
        check("simul_switching", {31'd0, mode_switching}, 1);
        repeat (4) tick();
        check("simul_wait_switching", {31'd0, mode_switching}, 0);
        check("simul_wait_busy", {31'd0, busy}, 1);
        check("simul_wait_one_hot", {29'd0, one_hot}, 3'b100);
        pulse_eof();
        check("simul_second_commit", {29'd0, one_hot}, 3'b001);
        wait_idle();

        // Active mode invalidated commits "no mode".
        strobe(3'b010);
        exp_commit.push_back(3'b010);
        pulse_eof();
        wait_idle();
        mode_valid = 3'b101;
        tick();
        check("lost_busy", {31'd0, busy}, 1);
        exp_commit.push_back(3'b000);
        pulse_eof();
        check("lost_one_hot", {29'd0, one_hot}, 0);
        check("lost_mode_change", {31'd0, mode_change}, 1);
        wait_idle();
        mode_valid = 3'b111;
        tick();

        // Pending request invalidated in WAIT_EOF.
        strobe(3'b100);
        check("pend_busy", {31'd0, busy}, 1);
        mode_valid = 3'b011;
        tick();
        exp_error++;
        check("pend_lost_err", {31'd0, req_error}, 1);
        check("pend_lost_idle", {31'd0, busy}, 0);
        mode_valid = 3'b111;
        tick();

        // Reset during settle drops the pending request.
        strobe(3'b010);
        exp_commit.push_back(3'b010);
        pulse_eof();
        strobe(3'b001);
        #2;
        rst = 1'b1;
        #1;
        check("arst_one_hot", {29'd0, one_hot}, 0);
        check("arst_switching", {31'd0, mode_switching}, 0);
        check("arst_busy", {31'd0, busy}, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        pulse_eof();
        repeat (6) tick();
        check("post_rst_one_hot", {29'd0, one_hot}, 0);
        check("post_rst_busy", {31'd0, busy}, 0);

        check("commits_left", exp_commit.size(), 0);
        check("errors_left", exp_error, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL global_timeout: got stalled expected finish");
        $fatal(1, "timeout");
    end

endmodule
